// File: rtl/jpeg_qnr_divider_pipe_if.sv
// Operand/result handshake bundle for the quantizer divider pipeline.
// The master drives operands and out_ready; the slave (the divider) returns results.
interface jpeg_qnr_divider_pipe_if #(
   parameter int unsigned DIVIDEND_W = 12,
   parameter int unsigned DIVISOR_W  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic [DIVIDEND_W-1:0] quotient;
   logic                  div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, div_by_zero
   );
endinterface

// File: rtl/jpeg_qnr_divider_pipe.sv
// Pipelined signed/unsigned restoring divider with round-half-away-from-zero,
// one quotient bit per stage, rigid shift register under a single advance enable.
module jpeg_qnr_divider_pipe #(
   parameter int unsigned DIVIDEND_W = 12,
   parameter int unsigned DIVISOR_W  = 8
) (
   input logic                    clk,
   input logic                    rst,
   jpeg_qnr_divider_pipe_if.slave bus
);
   localparam int unsigned N = DIVIDEND_W;

   logic                  advance;
   logic [N:0]            v_pipe;
   logic [N:0]            s_pipe;
   logic [N:0]            z_pipe;
   logic [DIVIDEND_W-1:0] mag_q [0:N];
   logic [DIVISOR_W-1:0]  div_q [0:N];
   logic [DIVISOR_W-1:0]  rem_q [0:N];
   logic [DIVIDEND_W-1:0] q_q   [0:N];

   logic [DIVISOR_W-1:0]  rem_nxt [1:N];
   logic [N:1]            bit_nxt;
   logic [DIVISOR_W:0]    trial;
   logic [DIVIDEND_W-1:0] mag_in;
   logic                  round_up;
   logic [DIVIDEND_W-1:0] q_round;
   logic [DIVIDEND_W-1:0] result;

   logic                  out_valid_q;
   logic [DIVIDEND_W-1:0] quotient_q;
   logic                  dbz_q;

   assign advance         = !out_valid_q || bus.out_ready;
   assign bus.in_ready    = advance;
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quotient_q;
   assign bus.div_by_zero = dbz_q;

   // -2048 negates to itself, which read unsigned is the wanted 2048.
   assign mag_in = bus.dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-bus.dividend) : bus.dividend;

   // Stored remainder is always < divisor, so DIVISOR_W bits hold it; the trial needs one more.
   always_comb begin
      trial = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         trial      = {rem_q[k-1], mag_q[k-1][DIVIDEND_W-1]};
         bit_nxt[k] = trial >= {1'b0, div_q[k-1]};
         rem_nxt[k] = bit_nxt[k] ? DIVISOR_W'(trial - {1'b0, div_q[k-1]}) : DIVISOR_W'(trial);
      end
   end

   always_comb begin
      round_up = {rem_q[N], 1'b0} >= {1'b0, div_q[N]};
      q_round  = q_q[N] + DIVIDEND_W'(round_up);
      if (z_pipe[N]) begin
         result = s_pipe[N] ? {1'b1, {(DIVIDEND_W-1){1'b0}}} : {1'b0, {(DIVIDEND_W-1){1'b1}}};
      end else begin
         result = s_pipe[N] ? DIVIDEND_W'(-q_round) : q_round;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_pipe      <= '0;
         s_pipe      <= '0;
         z_pipe      <= '0;
         for (int unsigned k = 0; k <= N; k++) begin
            mag_q[k] <= '0;
            div_q[k] <= '0;
            rem_q[k] <= '0;
            q_q[k]   <= '0;
         end
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         dbz_q       <= 1'b0;
      end else if (advance) begin
         v_pipe   <= {v_pipe[N-1:0], bus.in_valid};
         s_pipe   <= {s_pipe[N-1:0], bus.dividend[DIVIDEND_W-1]};
         z_pipe   <= {z_pipe[N-1:0], bus.divisor == '0};
         mag_q[0] <= mag_in;
         div_q[0] <= bus.divisor;
         rem_q[0] <= '0;
         q_q[0]   <= '0;
         for (int unsigned k = 1; k <= N; k++) begin
            mag_q[k] <= mag_q[k-1] << 1;
            div_q[k] <= div_q[k-1];
            rem_q[k] <= rem_nxt[k];
            q_q[k]   <= {q_q[k-1][DIVIDEND_W-2:0], bit_nxt[k]};
         end
         out_valid_q <= v_pipe[N];
         quotient_q  <= result;
         dbz_q       <= z_pipe[N];
      end
   end
endmodule

// File: tb/tb_jpeg_qnr_divider_pipe.sv
// Directed and random checks of the quantizer divider pipeline: arithmetic,
// rounding, divide-by-zero, latency, backpressure and mid-stream reset.
module tb_jpeg_qnr_divider_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   jpeg_qnr_divider_pipe_if #(.DIVIDEND_W(12), .DIVISOR_W(8)) bus ();

   jpeg_qnr_divider_pipe #(.DIVIDEND_W(12), .DIVISOR_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int          acc_q[$];
   logic [11:0] got_q[$];
   logic        got_z[$];
   int          got_lat[$];
   int          stim_n[$];
   int          stim_d[$];

   // Records the handshakes that the coming rising edge will perform.
   always begin
      @(negedge clk);
      #3;
      if (rst) begin
         acc_q.delete();
      end else begin
         if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
         if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.quotient);
            got_z.push_back(bus.div_by_zero);
            if (acc_q.size() > 0) got_lat.push_back(cyc + 1 - acc_q.pop_front());
            else got_lat.push_back(-1);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [12:0] ref_div(input int n, input int d);
      int a;
      int q;
      if (d == 0) return {1'b1, (n < 0) ? 12'h800 : 12'h7FF};
      a = (n < 0) ? -n : n;
      q = (2 * a + d) / (2 * d);
      if (n < 0) q = -q;
      return {1'b0, 12'(q)};
   endfunction

   task automatic step(input logic iv, input int n, input int d, input logic ordy, output logic acc);
      bus.in_valid  = iv;
      bus.dividend  = 12'(n);
      bus.divisor   = 8'(d);
      bus.out_ready = ordy;
      #1;
      acc = iv && bus.in_ready && !rst;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      logic acc;
      for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 1'b1, acc);
   endtask

   task automatic drive_stim();
      logic acc;
      got_q.delete();
      got_z.delete();
      got_lat.delete();
      for (int i = 0; i < stim_n.size(); i++) begin
         acc = 1'b0;
         for (int t = 0; t < 50 && !acc; t++) step(1'b1, stim_n[i], stim_d[i], 1'b1, acc);
      end
      idle(20);
   endtask

   task automatic test_reset();
      logic acc;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 77, 5, 1'b1, acc);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.quotient !== 12'd0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", bus.quotient); end
      total++; if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      @(negedge clk);
      #1;
   endtask

   task automatic test_arith();
      int en[5] = '{6, -6, 2, -2, 1};
      stim_n = '{100, -100, 24, -24, 23};
      stim_d = '{16, 16, 16, 16, 16};
      drive_stim();
      total++; if (got_q.size() != 5) begin bad++; $display("FAIL arith_count got=%0d want=5", got_q.size()); end
      for (int i = 0; i < 5; i++) if (i < got_q.size()) begin
         total++; if (got_q[i] !== 12'(en[i])) begin bad++; $display("FAIL arith_q[%0d] got=%0d want=%0d", i, $signed(got_q[i]), en[i]); end
         total++; if (got_z[i] !== 1'b0) begin bad++; $display("FAIL arith_dbz[%0d] got=%b want=0", i, got_z[i]); end
         total++; if (got_lat[i] != 14) begin bad++; $display("FAIL arith_latency[%0d] got=%0d want=14", i, got_lat[i]); end
      end
   endtask

   task automatic test_extremes();
      int en[5] = '{-2048, 1024, 8, 0, 0};
      stim_n = '{-2048, 2047, 2047, -1, 0};
      stim_d = '{1, 2, 255, 255, 7};
      drive_stim();
      total++; if (got_q.size() != 5) begin bad++; $display("FAIL extreme_count got=%0d want=5", got_q.size()); end
      for (int i = 0; i < 5; i++) if (i < got_q.size()) begin
         total++; if (got_q[i] !== 12'(en[i])) begin bad++; $display("FAIL extreme_q[%0d] got=%0d want=%0d", i, $signed(got_q[i]), en[i]); end
         total++; if (got_z[i] !== 1'b0) begin bad++; $display("FAIL extreme_dbz[%0d] got=%b want=0", i, got_z[i]); end
      end
   endtask

   task automatic test_div_zero();
      int   en[3] = '{2047, -2048, 3};
      logic ez[3] = '{1'b1, 1'b1, 1'b0};
      stim_n = '{500, -3, 9};
      stim_d = '{0, 0, 3};
      drive_stim();
      total++; if (got_q.size() != 3) begin bad++; $display("FAIL dbz_count got=%0d want=3", got_q.size()); end
      for (int i = 0; i < 3; i++) if (i < got_q.size()) begin
         total++; if (got_q[i] !== 12'(en[i])) begin bad++; $display("FAIL dbz_q[%0d] got=%0d want=%0d", i, $signed(got_q[i]), en[i]); end
         total++; if (got_z[i] !== ez[i]) begin bad++; $display("FAIL dbz_flag[%0d] got=%b want=%b", i, got_z[i], ez[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int          bn[20];
      int          bd[20];
      int          idx = 0;
      logic        acc;
      logic        ordy;
      logic        have_hold = 1'b0;
      logic [11:0] hold_q = '0;
      logic        hold_z = 1'b0;
      logic [12:0] e;
      for (int i = 0; i < 20; i++) begin
         bn[i] = i * 211 - 2000;
         bd[i] = (i == 7) ? 0 : ((i * 13) % 256) + 1;
      end
      got_q.delete();
      got_z.delete();
      got_lat.delete();
      for (int c = 0; c < 100 && idx < 20; c++) begin
         ordy = !(c >= 16 && c < 21);
         bus.out_ready = ordy;
         bus.in_valid  = 1'b1;
         bus.dividend  = 12'(bn[idx]);
         bus.divisor   = 8'(bd[idx]);
         #1;
         if (!ordy && bus.out_valid) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); end
            if (have_hold) begin
               total++; if (bus.quotient !== hold_q || bus.div_by_zero !== hold_z) begin
                  bad++; $display("FAIL stall_hold got=%0d/%b want=%0d/%b", $signed(bus.quotient), bus.div_by_zero, $signed(hold_q), hold_z);
               end
            end
            hold_q = bus.quotient;
            hold_z = bus.div_by_zero;
            have_hold = 1'b1;
         end
         acc = bus.in_ready;
         @(negedge clk);
         #1;
         if (acc) idx++;
      end
      total++; if (idx != 20) begin bad++; $display("FAIL stall_send_timeout got=%0d want=20", idx); end
      idle(20);
      total++; if (got_q.size() != 20) begin bad++; $display("FAIL stall_count got=%0d want=20", got_q.size()); end
      for (int i = 0; i < 20; i++) if (i < got_q.size()) begin
         e = ref_div(bn[i], bd[i]);
         total++; if (got_q[i] !== e[11:0] || got_z[i] !== e[12]) begin
            bad++; $display("FAIL stall_result[%0d] got=%0d/%b want=%0d/%b", i, $signed(got_q[i]), got_z[i], $signed(e[11:0]), e[12]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      int   seen = 0;
      got_q.delete();
      got_z.delete();
      got_lat.delete();
      for (int i = 0; i < 10; i++) step(1'b1, 100 + i, 3, 1'b1, acc);
      rst = 1'b1;
      step(1'b1, 999, 1, 1'b1, acc);
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (bus.out_valid) seen++;
         step(1'b0, 0, 0, 1'b1, acc);
      end
      total++; if (seen != 0) begin bad++; $display("FAIL midrst_out_valid got=%0d want=0", seen); end
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", got_q.size()); end
      stim_n = '{64};
      stim_d = '{8};
      drive_stim();
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", got_q.size()); end
      if (got_q.size() > 0) begin
         total++; if (got_q[0] !== 12'd8) begin bad++; $display("FAIL midrst_q got=%0d want=8", $signed(got_q[0])); end
         total++; if (got_lat[0] != 14) begin bad++; $display("FAIL midrst_latency got=%0d want=14", got_lat[0]); end
      end
   endtask

   task automatic test_soak();
      logic [12:0] expq[$];
      logic [12:0] e;
      logic [11:0] dv;
      int          dd;
      int          sent = 0;
      logic        acc;
      got_q.delete();
      got_z.delete();
      got_lat.delete();
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
         dv = 12'($urandom_range(0, 4095));
         dd = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
         step($urandom_range(0, 3) != 0, int'($signed(dv)), dd, $urandom_range(0, 3) != 0, acc);
         if (acc) begin
            expq.push_back(ref_div(int'($signed(dv)), dd));
            sent++;
         end
      end
      total++; if (sent != 10000) begin bad++; $display("FAIL soak_send_timeout got=%0d want=10000", sent); end
      idle(30);
      total++; if (got_q.size() != expq.size()) begin bad++; $display("FAIL soak_count got=%0d want=%0d", got_q.size(), expq.size()); end
      for (int i = 0; i < expq.size(); i++) if (i < got_q.size()) begin
         e = expq[i];
         total++; if (got_q[i] !== e[11:0] || got_z[i] !== e[12]) begin
            bad++; $display("FAIL soak_result[%0d] got=%0d/%b want=%0d/%b", i, $signed(got_q[i]), got_z[i], $signed(e[11:0]), e[12]);
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      test_reset();
      test_arith();
      test_extremes();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_soak();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
